dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter and access sequencer in front of the byte-addressed data memory. It shares the single memory port between the CPU load/store unit (requester C) and the DMA/program-loader port (requester D). It latches one command per transaction, drives the memory strobes for exactly one cycle, and returns a registered response. Misaligned, out-of-range and illegal-funct3 accesses are trapped before they reach memory.

## Interface
- `MEM_BYTES`, 4096: memory size in bytes. An access is in range iff `addr + size <= MEM_BYTES`.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `c_req` / `d_req`  in  1  request valid, C / D.
- `c_we` / `d_we`  in  1  1 = store, 0 = load.
- `c_funct3` / `d_funct3`  in  3  RV32I width code: 0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU.
- `c_addr` / `d_addr`  in  32  byte address.
- `c_wdata` / `d_wdata`  in  32  store data, right-aligned.
- `c_gnt` / `d_gnt`  out  1  one-cycle pulse: command consumed.
- `c_rvalid` / `d_rvalid`  out  1  one-cycle response pulse.
- `c_rdata` / `d_rdata`  out  32  load result; 0 for stores and errors.
- `c_err` / `d_err`  out  1  valid with rvalid; access rejected.
- `m_address`  out  32  to memory `address`.
- `m_writeData`  out  32  to memory `writeData`.
- `m_funct3`  out  3  to memory `funct3`.
- `m_MemWrite`, `m_MemRead`  out  1  memory strobes.
- `m_readData`  in  32  from memory `readData`, combinational.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Requests are sampled on each edge.
  - If any `req` is high, pick a winner, latch its we/funct3/addr/wdata and owner, pulse the winner's `gnt`, and go to ACCESS.
  - If no request, stay in IDLE.
- Fault check on the latched command, computed in ACCESS. An access faults on any of:
  - funct3 ∈ {3, 6, 7};
  - a store with funct3 ∈ {4, 5};
  - H/HU with `addr[0]` = 1;
  - W with `addr[1:0]` ≠ 0;
  - out of range.
- ACCESS (1 cycle):
  - `m_*` are driven from the latched command.
  - If not faulting: `m_MemWrite = we`, `m_MemRead = !we`.
  - If faulting: both strobes stay 0.
  - At the closing edge, capture `m_readData` (loads only; otherwise 0) and the fault bit, then go to RESP.
- RESP (1 cycle): the owner's `rvalid` = 1, with its `rdata`/`err` valid; then go to IDLE.
- Stores also receive `rvalid`, as the completion acknowledgement.
- Non-owner outputs are 0 in every state.
- Requests are not considered outside IDLE; a requester holds `req` and its command stable until `gnt`.
- The arbiter extends nothing: loaded data is returned exactly as memory presents it.

## Timing
- Reset values: FSM = IDLE; all `gnt`, `rvalid`, `err`, `m_MemWrite`, `m_MemRead` = 0; all `rdata`, `m_address`, `m_writeData`, `m_funct3` = 0; round-robin pointer = C.
- Latency:
  - `req` sampled at edge N;
  - `gnt` high in cycle N+1 (ACCESS);
  - memory write commits at edge N+2;
  - `rvalid` high in cycle N+2;
  - next grant earliest at edge N+3.
- Peak throughput: one access per 3 cycles.
- `m_address`, `m_writeData` and `m_funct3` hold their last values outside ACCESS. Only the strobes return to 0.
- Reset asserted mid-transaction:
  - takes effect immediately, with outputs as listed above;
  - a store in ACCESS does not commit if reset rises before the closing edge;
  - no `rvalid` is issued for the aborted access.
- A requester dropping `req` after `gnt` does not cancel its transaction.

## Configuration
- `DMEM_ARB_RR_EN` defined: simultaneous requests are resolved round-robin.
  - The pointer names the preferred requester.
  - After any grant, the pointer moves to the other requester.
  - A lone request is granted regardless of the pointer.
- Undefined: fixed priority, C always wins.
  - D is served only when `c_req` = 0 in IDLE.
  - D starvation is permitted.

## Test plan
- Store then load, C only: C stores W `0xDEADBEEF` @ 0x10, then loads W @ 0x10 → `c_gnt` one cycle after req, `m_MemWrite` exactly 1 cycle, `c_rvalid` with `c_rdata` = `0xDEADBEEF`, `c_err` = 0.
- Collision under RR: C and D request together from reset → grant order C, D, C, D with a 3-cycle spacing. Without the macro → C continuously, and D is granted only after C drops.
- Misalignment: load W @ 0x11 → no `m_MemRead` pulse; `rvalid` with `err` = 1, `rdata` = 0. H @ 0x13 behaves the same.
- Range and illegal funct3: W @ 0xFFE, store funct3 = 4, and load funct3 = 7 → each gives `err` = 1 and no strobe; memory contents unchanged.
- Reset mid-access: D store B `0x5A` @ 0x20 with reset asserted during ACCESS → all outputs 0 at once; a later load B @ 0x20 returns 0.
- Byte and half reads: after store W `0x8081F2F3` @ 0x40 → BU @ 0x40 returns `rdata` = `m_readData` (`0x000000F3`); no data is modified by the arbiter.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter and access sequencer for the byte-addressed data memory.
// Optional round-robin arbitration is enabled by defining DMEM_ARB_RR_EN; the default build uses fixed priority (C wins).
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [2:0]  c_funct3,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  output logic        c_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] m_address,
  output logic [31:0] m_writeData,
  output logic [2:0]  m_funct3,
  output logic        m_MemWrite,
  output logic        m_MemRead,
  input  logic [31:0] m_readData
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_nx;
  logic        owner_d;  // 0 = requester C, 1 = requester D
  logic        cmd_we;
  logic [2:0]  cmd_funct3;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        pick_d;
  logic        fault;
  logic [2:0]  size;
  logic [32:0] end_addr;

`ifdef DMEM_ARB_RR_EN
  logic rr_d;  // preferred requester on a collision: 0 = C, 1 = D
  assign pick_d = d_req & (~c_req | rr_d);
`else
  assign pick_d = d_req & ~c_req;
`endif

  // The memory port always mirrors the latched command, so it holds its last value outside ACCESS.
  assign m_address   = cmd_addr;
  assign m_writeData = cmd_wdata;
  assign m_funct3    = cmd_funct3;

  always_comb begin
    unique case (cmd_funct3[1:0])
      2'd0:    size = 3'd1;
      2'd1:    size = 3'd2;
      default: size = 3'd4;
    endcase
    // 33-bit sum so addresses near 2^32 cannot wrap back into range.
    end_addr = {1'b0, cmd_addr} + {30'd0, size};
    fault = (cmd_funct3 == 3'd3) || (cmd_funct3[2:1] == 2'b11)
         || (cmd_we && cmd_funct3[2])
         || ((cmd_funct3[1:0] == 2'd1) && cmd_addr[0])
         || ((cmd_funct3 == 3'd2) && (cmd_addr[1:0] != 2'd0))
         || (end_addr > 33'(MEM_BYTES));
  end

  // NOTE: every output of this block is given a default before the case so no latch is inferred.
  always_comb begin
    state_nx   = state;
    c_gnt      = 1'b0;
    d_gnt      = 1'b0;
    c_rvalid   = 1'b0;
    d_rvalid   = 1'b0;
    c_rdata    = '0;
    d_rdata    = '0;
    c_err      = 1'b0;
    d_err      = 1'b0;
    m_MemWrite = 1'b0;
    m_MemRead  = 1'b0;
    unique case (state)
      IDLE: begin
        if (c_req || d_req) state_nx = ACCESS;
      end
      ACCESS: begin
        state_nx   = RESP;
        c_gnt      = ~owner_d;
        d_gnt      = owner_d;
        m_MemWrite = ~fault & cmd_we;
        m_MemRead  = ~fault & ~cmd_we;
      end
      RESP: begin
        state_nx = IDLE;
        if (owner_d) begin
          d_rvalid = 1'b1;
          d_rdata  = rdata_q;
          d_err    = err_q;
        end else begin
          c_rvalid = 1'b1;
          c_rdata  = rdata_q;
          c_err    = err_q;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner_d    <= 1'b0;
      cmd_we     <= 1'b0;
      cmd_funct3 <= '0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      rr_d       <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if ((state == IDLE) && (c_req || d_req)) begin
        owner_d    <= pick_d;
        cmd_we     <= pick_d ? d_we     : c_we;
        cmd_funct3 <= pick_d ? d_funct3 : c_funct3;
        cmd_addr   <= pick_d ? d_addr   : c_addr;
        cmd_wdata  <= pick_d ? d_wdata  : c_wdata;
`ifdef DMEM_ARB_RR_EN
        rr_d       <= ~pick_d;
`endif
      end
      if (state == ACCESS) begin
        err_q   <= fault;
        rdata_q <= (~cmd_we & ~fault) ? m_readData : 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural RV32I data memory and a response scoreboard.
// Expectations for collisions follow DMEM_ARB_RR_EN when it is defined for the build.
module tb_dmem_arbiter;
  localparam int MEM_BYTES = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_req, c_we, d_req, d_we;
  logic [2:0]  c_funct3, d_funct3;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic        c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err;
  logic [31:0] c_rdata, d_rdata;
  logic [31:0] m_address, m_writeData, m_readData;
  logic [2:0]  m_funct3;
  logic        m_MemWrite, m_MemRead;
  logic        init_mem;

  typedef struct {
    logic        d;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  dmem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_funct3(c_funct3), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .m_address(m_address), .m_writeData(m_writeData), .m_funct3(m_funct3),
    .m_MemWrite(m_MemWrite), .m_MemRead(m_MemRead), .m_readData(m_readData)
  );

  always #5 clk = ~clk;

  // Data memory: synchronous write, combinational read with RV32I sign/zero extension.
  logic [7:0]  mem [MEM_BYTES];
  logic [11:0] ra;
  logic [7:0]  b0, b1, b2, b3;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'h00;
    end else if (m_MemWrite) begin
      mem[m_address[11:0]] <= m_writeData[7:0];
      if (m_funct3[1:0] != 2'd0) mem[m_address[11:0] + 12'd1] <= m_writeData[15:8];
      if (m_funct3[1:0] == 2'd2) begin
        mem[m_address[11:0] + 12'd2] <= m_writeData[23:16];
        mem[m_address[11:0] + 12'd3] <= m_writeData[31:24];
      end
    end
  end

  always_comb begin
    ra = m_address[11:0];
    b0 = mem[ra];
    b1 = mem[ra + 12'd1];
    b2 = mem[ra + 12'd2];
    b3 = mem[ra + 12'd3];
    m_readData = {b3, b2, b1, b0};
    case (m_funct3)
      3'd0: m_readData = {{24{b0[7]}}, b0};
      3'd1: m_readData = {{16{b1[7]}}, b1, b0};
      3'd4: m_readData = {24'd0, b0};
      3'd5: m_readData = {16'd0, b1, b0};
      default: ;
    endcase
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    c_req = 0; c_we = 0; c_funct3 = 0; c_addr = 0; c_wdata = 0;
    d_req = 0; d_we = 0; d_funct3 = 0; d_addr = 0; d_wdata = 0;
  endtask

  task automatic drive(input logic d, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (d) begin
      d_req = 1; d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wdata;
    end else begin
      c_req = 1; c_we = we; c_funct3 = f3; c_addr = addr; c_wdata = wdata;
    end
  endtask

  // One full transaction: request, grant latency, ACCESS-cycle strobes, scoreboarded response.
  task automatic txn(input string name, input logic d, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err);
    int   n;
    logic got;
    exp_t e;
    logic [31:0] own_rdata, oth_rdata;
    logic own_err;
    @(negedge clk);
    drive(d, we, f3, addr, wdata);
    sb.push_back('{d: d, rdata: exp_rdata, err: exp_err});
    n = 0; got = 0;
    while (!got && n < 10) begin
      @(negedge clk); n++;
      got = d ? d_gnt : c_gnt;
    end
    checks++;
    if (!got || n != 1 || (d ? c_gnt : d_gnt) !== 1'b0) begin
      errors++;
      $display("FAIL %s gnt: got=%0b after %0d cycles, required 1 after 1 cycle", name, got, n);
    end
    if (d) d_req = 0; else c_req = 0;
    checks++;
    if (m_MemWrite !== (we & ~exp_err) || m_MemRead !== (~we & ~exp_err)) begin
      errors++;
      $display("FAIL %s strobes: wr=%b rd=%b, required wr=%b rd=%b", name, m_MemWrite, m_MemRead,
               we & ~exp_err, ~we & ~exp_err);
    end
    checks++;
    if (m_address !== addr || m_funct3 !== f3 || (we && m_writeData !== wdata)) begin
      errors++;
      $display("FAIL %s mem_port: addr=%h f3=%0d wd=%h, required addr=%h f3=%0d wd=%h",
               name, m_address, m_funct3, m_writeData, addr, f3, wdata);
    end
    n = 0; got = 0;
    while (!got && n < 10) begin
      @(negedge clk); n++;
      got = c_rvalid | d_rvalid;
    end
    checks++;
    if (!got || sb.size() == 0) begin
      errors++;
      $display("FAIL %s rvalid: no response within %0d cycles", name, n);
    end else begin
      e = sb.pop_front();
      own_rdata = e.d ? d_rdata : c_rdata;
      oth_rdata = e.d ? c_rdata : d_rdata;
      own_err   = e.d ? d_err : c_err;
      if (n != 1 || {d_rvalid, c_rvalid} !== (e.d ? 2'b10 : 2'b01) || own_rdata !== e.rdata ||
          own_err !== e.err || oth_rdata !== 32'd0 || m_MemWrite !== 1'b0 || m_MemRead !== 1'b0) begin
        errors++;
        $display("FAIL %s resp: lat=%0d rv(d,c)=%b%b rdata=%h err=%b other=%h, required lat=1 owner=%s rdata=%h err=%b",
                 name, n, d_rvalid, c_rvalid, own_rdata, own_err, oth_rdata, e.d ? "D" : "C",
                 e.rdata, e.err);
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; init_mem = 1;
    @(negedge clk);
    init_mem = 0;
    @(negedge clk);
    checks++;
    if ({c_gnt, d_gnt, c_rvalid, d_rvalid, c_err, d_err, m_MemWrite, m_MemRead} !== 8'd0) begin
      errors++;
      $display("FAIL reset_ctrl: %b, required 00000000",
               {c_gnt, d_gnt, c_rvalid, d_rvalid, c_err, d_err, m_MemWrite, m_MemRead});
    end
    checks++;
    if (c_rdata !== 0 || d_rdata !== 0 || m_address !== 0 || m_writeData !== 0 || m_funct3 !== 0) begin
      errors++;
      $display("FAIL reset_data: crd=%h drd=%h addr=%h wd=%h f3=%0d, required all 0",
               c_rdata, d_rdata, m_address, m_writeData, m_funct3);
    end
    reset = 0;
    @(negedge clk);
    checks++;
    if (c_gnt !== 0 || d_gnt !== 0) begin
      errors++;
      $display("FAIL reset_idle_gnt: c=%b d=%b, required 0 0", c_gnt, d_gnt);
    end
  endtask

  task automatic test_store_load();
    txn("c_sw_10", 0, 1, 3'd2, 32'h10, 32'hDEADBEEF, 32'd0, 0);
    txn("c_lw_10", 0, 0, 3'd2, 32'h10, 32'd0, 32'hDEADBEEF, 0);
    @(negedge clk);
    checks++;
    if (m_address !== 32'h10 || m_funct3 !== 3'd2 || m_MemRead !== 0 || m_MemWrite !== 0) begin
      errors++;
      $display("FAIL hold_port: addr=%h f3=%0d rd=%b wr=%b, required addr=00000010 f3=2 rd=0 wr=0",
               m_address, m_funct3, m_MemRead, m_MemWrite);
    end
  endtask

  task automatic test_byte_half();
    txn("d_sw_40", 1, 1, 3'd2, 32'h40, 32'h8081F2F3, 32'd0, 0);
    txn("c_lbu_40", 0, 0, 3'd4, 32'h40, 32'd0, 32'h000000F3, 0);
    txn("d_lb_40", 1, 0, 3'd0, 32'h40, 32'd0, 32'hFFFFFFF3, 0);
    txn("c_lhu_42", 0, 0, 3'd5, 32'h42, 32'd0, 32'h00008081, 0);
    txn("d_lh_42", 1, 0, 3'd1, 32'h42, 32'd0, 32'hFFFF8081, 0);
    txn("c_sb_44", 0, 1, 3'd0, 32'h44, 32'h123456AB, 32'd0, 0);
    txn("d_lw_44", 1, 0, 3'd2, 32'h44, 32'd0, 32'h000000AB, 0);
  endtask

  task automatic test_misalign();
    txn("c_lw_11", 0, 0, 3'd2, 32'h11, 32'd0, 32'd0, 1);
    txn("d_lh_13", 1, 0, 3'd1, 32'h13, 32'd0, 32'd0, 1);
    txn("c_lhu_41", 0, 0, 3'd5, 32'h41, 32'd0, 32'd0, 1);
    txn("d_sw_42", 1, 1, 3'd2, 32'h42, 32'h11111111, 32'd0, 1);
    txn("c_lw_40_chk", 0, 0, 3'd2, 32'h40, 32'd0, 32'h8081F2F3, 0);
  endtask

  task automatic test_range_illegal();
    txn("c_lw_ffe", 0, 0, 3'd2, 32'hFFE, 32'd0, 32'd0, 1);
    txn("c_lw_ffc", 0, 0, 3'd2, 32'hFFC, 32'd0, 32'd0, 0);
    txn("d_lbu_fff", 1, 0, 3'd4, 32'hFFF, 32'd0, 32'd0, 0);
    txn("d_lb_1000", 1, 0, 3'd0, 32'h1000, 32'd0, 32'd0, 1);
    txn("c_lw_wrap", 0, 0, 3'd2, 32'hFFFFFFFC, 32'd0, 32'd0, 1);
    txn("c_st_f3_4", 0, 1, 3'd4, 32'h10, 32'h12345678, 32'd0, 1);
    txn("d_st_f3_3", 1, 1, 3'd3, 32'h10, 32'h12345678, 32'd0, 1);
    txn("c_ld_f3_7", 0, 0, 3'd7, 32'h10, 32'd0, 32'd0, 1);
    txn("d_lw_10_chk", 1, 0, 3'd2, 32'h10, 32'd0, 32'hDEADBEEF, 0);
  endtask

  task automatic test_reset_mid();
    int   n;
    int   rv;
    logic got;
    @(negedge clk);
    drive(1, 1, 3'd0, 32'h20, 32'h0000005A);
    n = 0; got = 0;
    while (!got && n < 10) begin
      @(negedge clk); n++;
      got = d_gnt;
    end
    checks++;
    if (!got || m_MemWrite !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_access: gnt=%b wr=%b, required 1 1", got, m_MemWrite);
    end
    reset = 1;
    #1;
    checks++;
    if ({c_gnt, d_gnt, c_rvalid, d_rvalid, c_err, d_err, m_MemWrite, m_MemRead} !== 8'd0 ||
        m_address !== 0 || m_writeData !== 0 || m_funct3 !== 0 || d_rdata !== 0) begin
      errors++;
      $display("FAIL rstmid_outputs: ctl=%b addr=%h wd=%h f3=%0d, required all 0",
               {c_gnt, d_gnt, c_rvalid, d_rvalid, c_err, d_err, m_MemWrite, m_MemRead},
               m_address, m_writeData, m_funct3);
    end
    d_req = 0;
    @(negedge clk);
    reset = 0;
    rv = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (c_rvalid || d_rvalid || c_gnt || d_gnt) rv++;
    end
    checks++;
    if (rv != 0) begin
      errors++;
      $display("FAIL rstmid_no_resp: %0d active cycles, required 0", rv);
    end
    txn("d_lbu_20", 1, 0, 3'd4, 32'h20, 32'd0, 32'd0, 0);
  endtask

  task automatic test_collision();
    int   gcyc [4];
    logic gown [4];
    int   ng;
    int   n;
    logic got;
    logic exp_own [4];
`ifdef DMEM_ARB_RR_EN
    exp_own = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_own = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    @(negedge clk);
    reset = 1;
    drive(0, 0, 3'd2, 32'h10, 32'd0);
    drive(1, 0, 3'd2, 32'h40, 32'd0);
    @(negedge clk);
    reset = 0;
    ng = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if ((c_gnt || d_gnt) && ng < 4) begin
        gcyc[ng] = cyc;
        gown[ng] = d_gnt;
        ng++;
      end
    end
    checks++;
    if (ng != 4) begin
      errors++;
      $display("FAIL coll_count: %0d grants, required 4", ng);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (gown[i] !== exp_own[i] || gcyc[i] != 1 + 3 * i) begin
          errors++;
          $display("FAIL coll_grant%0d: owner=%s cycle=%0d, required owner=%s cycle=%0d", i,
                   gown[i] ? "D" : "C", gcyc[i], exp_own[i] ? "D" : "C", 1 + 3 * i);
        end
      end
    end
    c_req = 0;
    n = 0; got = 0;
    while (!got && n < 10) begin
      @(negedge clk); n++;
      got = c_gnt | d_gnt;
    end
    checks++;
    if (!got || d_gnt !== 1'b1 || c_gnt !== 1'b0) begin
      errors++;
      $display("FAIL coll_d_after_c_drop: got=%b c=%b d=%b, required D grant", got, c_gnt, d_gnt);
    end
    d_req = 0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_half();
    test_misalign();
    test_range_illegal();
    test_reset_mid();
    test_collision();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
